// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter that sequences the shared 8-bit ALU
// through issue/capture/respond for the sequencer (0) and the index unit (1).

package control;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    SHL = 3'd6,
    RSV = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ZERO  = 2'd1,
    CARRY = 2'd2
  } alu_flag_e;

endpackage

module alu_scheduler
  import control::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  alu_op_e         req_op0,
  input  alu_op_e         req_op1,
  input  logic [7:0]      req_a0,
  input  logic [7:0]      req_a1,
  input  logic [7:0]      req_b0,
  input  logic [7:0]      req_b1,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [7:0]      rsp_data,
  output alu_flag_e       rsp_flag,
  output alu_op_e         alu_op,
  output logic [7:0]      alu_reg1,
  output logic [7:0]      alu_reg2,
  output logic            alu_enable,
  input  logic [7:0]      alu_result,
  input  alu_flag_e       alu_flag,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  state_e     state_r;
  logic       last_r;
  logic       winner_r;
  alu_op_e    op_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [7:0] data_r;
  alu_flag_e  flag_r;
  logic [1:0] rsp_valid_r;
  logic       enable_r;
  logic       busy_r;

  logic       winner_s;
  logic [1:0] grant_s;
  logic       accept_s;
  logic       done_s;

  // Round-robin winner, combinational grant in IDLE, response completion.
  always_comb begin
    winner_s = 1'b0;
    grant_s  = 2'b00;
    accept_s = 1'b0;
    done_s   = 1'b0;
    if (req_valid == 2'b11) begin
      winner_s = ~last_r;
    end else if (req_valid == 2'b10) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    // Gated by reset so the grant never shows while the block is being cleared.
    if ((state_r == IDLE) && !reset && (req_valid != 2'b00)) begin
      grant_s = onehot2(winner_s);
    end else begin
      grant_s = 2'b00;
    end
    accept_s = ((grant_s & req_valid) != 2'b00);
    if (state_r == RESPOND) begin
      done_s = rsp_ready[winner_r];
    end else begin
      done_s = 1'b0;
    end
  end

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      winner_r    <= 1'b0;
      op_r        <= NOP;
      a_r         <= 8'h00;
      b_r         <= 8'h00;
      data_r      <= 8'h00;
      flag_r      <= NONE;
      rsp_valid_r <= 2'b00;
      enable_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            winner_r <= winner_s;
            op_r     <= winner_s ? req_op1 : req_op0;
            a_r      <= winner_s ? req_a1 : req_a0;
            b_r      <= winner_s ? req_b1 : req_b0;
            busy_r   <= 1'b1;
            state_r  <= ISSUE;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          enable_r <= 1'b1;
          state_r  <= CAPTURE;
        end
        CAPTURE: begin
          // Op stays on the ALU here: its CARRY qualification depends on it.
          data_r      <= alu_result;
          flag_r      <= alu_flag;
          enable_r    <= 1'b0;
          rsp_valid_r <= onehot2(winner_r);
          state_r     <= RESPOND;
        end
        RESPOND: begin
          if (done_s) begin
            rsp_valid_r <= 2'b00;
            last_r      <= winner_r;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESPOND;
          end
        end
        default: begin
          rsp_valid_r <= 2'b00;
          enable_r    <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = data_r;
  assign rsp_flag   = flag_r;
  assign alu_op     = op_r;
  assign alu_reg1   = a_r;
  assign alu_reg2   = b_r;
  assign alu_enable = enable_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural ALU plus a response scoreboard.

module tb_alu_scheduler;
  import control::*;

  logic       clock;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  alu_op_e    req_op0, req_op1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_data;
  alu_flag_e  rsp_flag;
  alu_op_e    alu_op;
  logic [7:0] alu_reg1, alu_reg2;
  logic       alu_enable;
  logic [7:0] alu_result;
  alu_flag_e  alu_flag;
  logic       busy;

  typedef struct packed {
    logic       r;
    logic [7:0] d;
    alu_flag_e  f;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  alu_scheduler dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_op(alu_op), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
    .alu_enable(alu_enable), .alu_result(alu_result), .alu_flag(alu_flag),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: registered result; unimplemented ops keep the held value.
  logic [7:0] alu_hold = 8'h00;
  logic       alu_cy = 1'b0;
  always @(posedge clock) begin
    case (alu_op)
      ADD:     {alu_cy, alu_hold} <= {1'b0, alu_reg1} + {1'b0, alu_reg2};
      SUB:     {alu_cy, alu_hold} <= {1'b0, alu_reg1} - {1'b0, alu_reg2};
      AND:     {alu_cy, alu_hold} <= {1'b0, alu_reg1 & alu_reg2};
      OR:      {alu_cy, alu_hold} <= {1'b0, alu_reg1 | alu_reg2};
      XOR:     {alu_cy, alu_hold} <= {1'b0, alu_reg1 ^ alu_reg2};
      SHL:     {alu_cy, alu_hold} <= {alu_reg1, 1'b0};
      default: {alu_cy, alu_hold} <= {alu_cy, alu_hold};
    endcase
  end

  always_comb begin
    alu_flag = NONE;
    if (alu_cy && (alu_op == ADD || alu_op == SUB || alu_op == SHL)) alu_flag = CARRY;
    else if (alu_hold == 8'h00) alu_flag = ZERO;
    else alu_flag = NONE;
  end

  assign alu_result = alu_enable ? alu_hold : 8'h00;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input logic r);
    return r ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_rsp();
    exp_t e;
    check_val("sb_depth", sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("rsp_valid", rsp_valid, onehot(e.r));
      check_val("rsp_data", rsp_data, e.d);
      check_val("rsp_flag", rsp_flag, e.f);
    end
  endtask

  // Requester r is presenting; expects grant now, response 2 cycles after accept.
  task automatic serve(input logic r, input logic [7:0] ed, input alu_flag_e ef, input logic drop);
    exp_t e;
    check_val("grant", req_ready, onehot(r));
    e.r = r; e.d = ed; e.f = ef;
    sb_q.push_back(e);
    step();
    if (drop) req_valid[r] = 1'b0;
    check_val("issue_enable", alu_enable, 1'b0);
    check_val("issue_busy", busy, 1'b1);
    check_val("issue_ready", req_ready, 2'b00);
    step();
    check_val("capture_enable", alu_enable, 1'b1);
    check_val("capture_rsp_valid", rsp_valid, 2'b00);
    step();
    check_rsp();
    check_val("respond_enable", alu_enable, 1'b0);
    step();
    check_val("done_rsp_valid", rsp_valid, 2'b00);
    check_val("done_busy", busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_op0 = NOP; req_op1 = NOP;
    req_a0 = 8'h00; req_a1 = 8'h00; req_b0 = 8'h00; req_b1 = 8'h00;
    step(); step();
    check_val("rst_req_ready", req_ready, 2'b00);
    check_val("rst_rsp_valid", rsp_valid, 2'b00);
    check_val("rst_rsp_data", rsp_data, 8'h00);
    check_val("rst_rsp_flag", rsp_flag, NONE);
    check_val("rst_enable", alu_enable, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_alu_op", alu_op, NOP);
    reset = 1'b0;
    rsp_ready = 2'b11;

    // Single ADD and SUB-to-zero, then carry/borrow cases.
    req_valid = 2'b01; req_op0 = ADD; req_a0 = 8'hF0; req_b0 = 8'h20; #1;
    serve(1'b0, 8'h10, CARRY, 1'b1);
    req_valid = 2'b10; req_op1 = SUB; req_a1 = 8'h05; req_b1 = 8'h05; #1;
    serve(1'b1, 8'h00, ZERO, 1'b1);
    req_valid = 2'b01; req_op0 = SUB; req_a0 = 8'h03; req_b0 = 8'h05; #1;
    serve(1'b0, 8'hFE, CARRY, 1'b1);
    req_valid = 2'b10; req_op1 = SHL; req_a1 = 8'h81; req_b1 = 8'h00; #1;
    serve(1'b1, 8'h02, CARRY, 1'b1);

    // Backpressure with wrong-requester ready and a held request from req 1.
    req_valid = 2'b01; req_op0 = ADD; req_a0 = 8'h01; req_b0 = 8'h02; #1;
    check_val("bp_grant", req_ready, 2'b01);
    sb_q.push_back('{1'b0, 8'h03, NONE});
    rsp_ready = 2'b00;
    step();
    req_valid = 2'b11; req_op1 = AND; req_a1 = 8'h3C; req_b1 = 8'hF0;
    step(); step();
    check_rsp();
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("bp_rsp_valid", rsp_valid, 2'b01);
      check_val("bp_rsp_data", rsp_data, 8'h03);
      check_val("bp_rsp_flag", rsp_flag, NONE);
      check_val("bp_busy", busy, 1'b1);
      check_val("bp_req_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b01; req_valid = 2'b10;
    step();
    check_val("bp_done_rsp_valid", rsp_valid, 2'b00);
    check_val("bp_done_busy", busy, 1'b0);
    rsp_ready = 2'b11;
    serve(1'b1, 8'h30, NONE, 1'b1);

    // Reset during CAPTURE drops the operation.
    req_valid = 2'b10; req_op1 = OR; req_a1 = 8'h0F; req_b1 = 8'h30; #1;
    check_val("rc_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    step();
    check_val("rc_capture_enable", alu_enable, 1'b1);
    reset = 1'b1;
    step();
    check_val("rc_enable", alu_enable, 1'b0);
    check_val("rc_rsp_valid", rsp_valid, 2'b00);
    check_val("rc_busy", busy, 1'b0);
    check_val("rc_rsp_data", rsp_data, 8'h00);
    reset = 1'b0;
    req_valid = 2'b10; #1;
    serve(1'b1, 8'h3F, NONE, 1'b1);
    // Unimplemented op returns the previously held value.
    req_valid = 2'b01; req_op0 = NOP; req_a0 = 8'hAA; req_b0 = 8'h55; #1;
    serve(1'b0, 8'h3F, NONE, 1'b1);

    // Contention from reset: 0, 1, then 0 again.
    req_valid = 2'b11;
    req_op0 = XOR; req_a0 = 8'h0F; req_b0 = 8'hFF;
    req_op1 = AND; req_a1 = 8'h3C; req_b1 = 8'hF0;
    reset = 1'b1;
    step(); step();
    check_val("ct_rst_ready", req_ready, 2'b00);
    reset = 1'b0; #1;
    serve(1'b0, 8'hF0, NONE, 1'b0);
    serve(1'b1, 8'h30, NONE, 1'b0);
    serve(1'b0, 8'hF0, NONE, 1'b1);
    req_valid = 2'b00;
    step();

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Arbitrates shared access to the 8-bit ALU between two requesters: requester 0 is the instruction sequencer and requester 1 is the address/index unit. It accepts one operation at a time through a valid/ready handshake and sequences the ALU's registered compute cycle. During the capture cycle it alone drives the ALU's tri-state result enable. It returns the captured result and flag to the winning requester through a held response handshake.

## Interface
Parameters: none. Operand width is fixed at 8. Op and flag types are `alu_op_e` and `alu_flag_e` from package `control`.

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  2  per-requester request valid
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req_op0`, `req_op1`  in  alu_op_e  requested operation
- `req_a0`, `req_a1`  in  8  operand 1 (ALU register1)
- `req_b0`, `req_b1`  in  8  operand 2 (ALU register2)
- `rsp_valid`  out  2  per-requester response valid; at most one bit high
- `rsp_ready`  in  2  per-requester response accept
- `rsp_data`  out  8  captured ALU result
- `rsp_flag`  out  alu_flag_e  captured ALU flag
- `alu_op`  out  alu_op_e  to ALU op
- `alu_reg1`, `alu_reg2`  out  8  to ALU operands
- `alu_enable`  out  1  to ALU enable (result bus drive)
- `alu_result`  in  8  from ALU result
- `alu_flag`  in  alu_flag_e  from ALU flag
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- **IDLE**
  - Computes a winner among the asserted `req_valid` bits and raises `req_ready` for the winner only, combinationally.
  - Round-robin rule: on a tie the winner is the requester not granted last.
  - The last-grant pointer resets so that requester 0 wins the first tie.
  - On `req_valid[w] & req_ready[w]`, the block latches op, a, b and the winner index, then moves to ISSUE.
- **ISSUE**
  - Drives the latched op and operands onto `alu_op`/`alu_reg1`/`alu_reg2`. `alu_enable` stays 0.
  - The ALU registers its result on the closing edge.
  - Always moves to CAPTURE.
- **CAPTURE**
  - Holds op and operands unchanged, because the ALU flag's CARRY qualification depends on op. Drives `alu_enable`=1.
  - Registers `alu_result` into `rsp_data` and `alu_flag` into `rsp_flag` on the closing edge.
  - Always moves to RESPOND.
- **RESPOND**
  - `rsp_valid[winner]`=1. `rsp_data`/`rsp_flag` are stable.
  - On `rsp_ready[winner]`, updates the last-grant pointer to the winner and moves to IDLE.
  - The other requester's `rsp_ready` is ignored.
- `alu_op`/`alu_reg1`/`alu_reg2` always drive the latched values; they reset to 0 / the first enum value.
- `alu_enable` is high only in CAPTURE. It is never high during or immediately after reset.
- Ops are passed through unfiltered. Ops that the ALU does not implement return its previously held value, and the flag reflects that value.
- `req_ready` is 0 in all states except IDLE. A requester may hold `req_valid` across a busy period without loss.
- **Reset mid-operation:** returns to IDLE from any state, drops any in-flight operation and pending response, clears `rsp_valid`, and resets the pointer.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_flag`=NONE, `alu_enable`=0, `busy`=0.

## Timing
- Acceptance at edge E0 → ISSUE during E0–E1 → CAPTURE during E1–E2 → `rsp_valid` high from E2.
- Latency from accept edge to response valid: 2 cycles.
- With `rsp_ready` already high, the response handshake completes at E3 and the next accept is possible at E4. Peak throughput is therefore 1 op per 4 cycles.
- **Backpressure:** RESPOND holds indefinitely. Outputs must not change while `rsp_valid`=1 and `rsp_ready`=0.
- A request arriving while busy is not accepted until the IDLE cycle after the response completes.
- **Simultaneous requests in IDLE:** exactly one is granted. The loser keeps `req_ready`=0 and wins the next IDLE if it still requests.

## Test plan
- **Single ADD:** reset, then requester 0 sends ADD a=0xF0 b=0x20.
  - Required: `req_ready[0]` high in the same cycle.
  - Required: `alu_enable` high exactly one cycle (CAPTURE).
  - Required: `rsp_valid[0]` two cycles after accept, with `rsp_data`=0x10 and `rsp_flag`=CARRY.
- **SUB to zero:** requester 1 sends SUB a=0x05 b=0x05 → `rsp_valid[1]`, `rsp_data`=0x00, `rsp_flag`=ZERO; `rsp_valid[0]` stays 0.
- **Contention:** both requesters hold valid from reset with XOR 0x0F^0xFF (req 0) and AND 0x3C&0xF0 (req 1).
  - Required: req 0 is served first → 0xF0/NONE; req 1 second → 0x30/NONE.
  - Required: the third round, with both still requesting, grants req 0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles during RESPOND → `rsp_valid`, `rsp_data` and `rsp_flag` are stable, `busy`=1, and both `req_ready` bits are 0. Response completes on the cycle `rsp_ready` rises.
- **Reset in CAPTURE:** assert `reset` in the CAPTURE cycle → next cycle shows IDLE with `alu_enable`=0, `rsp_valid`=0, `busy`=0. The following request completes normally.
- **Wrong-requester ready:** in RESPOND for req 0, assert only `rsp_ready[1]` → no completion; state remains RESPOND.
